// File: rtl/mean3x3_scan_ctrl.sv
// Raster-scan controller for the 3x3 window fetch block: requests each pixel's window,
// averages the nine returned values and writes the floor mean to the result memory.
module mean3x3_scan_ctrl #(
    parameter int ROW_BITS = 7,
    parameter int COL_BITS = 7,
    parameter int TIMEOUT  = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         win_start,
    output logic [ROW_BITS+COL_BITS-1:0] win_addr,
    input  logic                         win_finish,
    input  logic [7:0]                   win_v_1_1,
    input  logic [7:0]                   win_v_1_2,
    input  logic [7:0]                   win_v_1_3,
    input  logic [7:0]                   win_v_2_1,
    input  logic [7:0]                   win_v_2_2,
    input  logic [7:0]                   win_v_2_3,
    input  logic [7:0]                   win_v_3_1,
    input  logic [7:0]                   win_v_3_2,
    input  logic [7:0]                   win_v_3_3,
    output logic [ROW_BITS+COL_BITS-1:0] res_addr,
    output logic [7:0]                   res_data,
    output logic                         res_we,
    input  logic                         res_ready
);
    localparam int AW = ROW_BITS + COL_BITS;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WCNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [AW-1:0] pix_r, pix_s;
    logic [CW-1:0] wcnt_r, wcnt_s;
    logic [11:0]   sum_r, sum_s;
    logic          err_r, err_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          win_start_r, win_start_s;
    logic          res_we_r, res_we_s;
    logic [AW-1:0] win_addr_r, win_addr_s;
    logic [AW-1:0] res_addr_r, res_addr_s;
    logic [7:0]    res_data_r, res_data_s;
    logic [11:0]   win_sum_s;
    logic          pix_last_s;

    // floor(sum/9) via reciprocal multiply; exact for every sum of nine 8-bit values
    function automatic logic [7:0] div9(input logic [11:0] sum);
        return 8'((32'(sum) * 32'd7282) >> 16);
    endfunction

    assign win_sum_s = 12'(win_v_1_1) + 12'(win_v_1_2) + 12'(win_v_1_3)
                     + 12'(win_v_2_1) + 12'(win_v_2_2) + 12'(win_v_2_3)
                     + 12'(win_v_3_1) + 12'(win_v_3_2) + 12'(win_v_3_3);
    assign pix_last_s = (pix_r == {AW{1'b1}});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_ISSUE;
                else       state_s = S_IDLE;
            end
            S_ISSUE: state_s = S_WAIT;
            S_WAIT: begin
                if (win_finish)                state_s = S_WRITE;
                else if (wcnt_r == WCNT_LAST)  state_s = S_IDLE;
                else                           state_s = S_WAIT;
            end
            S_WRITE: begin
                if (res_ready && pix_last_s)   state_s = S_FIN;
                else if (res_ready)            state_s = S_ISSUE;
                else                           state_s = S_WRITE;
            end
            S_FIN:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath next values: pixel counter, wait counter, latched sum, sticky error
    always_comb begin
        pix_s  = pix_r;
        wcnt_s = wcnt_r;
        sum_s  = sum_r;
        err_s  = err_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    pix_s = '0;
                    err_s = 1'b0;
                end else begin
                    pix_s = pix_r;
                end
            end
            S_ISSUE: wcnt_s = '0;
            S_WAIT: begin
                if (win_finish) begin
                    sum_s = win_sum_s;
                end else if (wcnt_r == WCNT_LAST) begin
                    err_s = 1'b1;
                end else begin
                    wcnt_s = wcnt_r + CW'(1);
                end
            end
            S_WRITE: begin
                if (res_ready && !pix_last_s) pix_s = pix_r + AW'(1);
                else                          pix_s = pix_r;
            end
            S_FIN:   pix_s = pix_r;
            default: pix_s = pix_r;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        busy_s      = (state_s == S_ISSUE) || (state_s == S_WAIT) || (state_s == S_WRITE);
        done_s      = (state_s == S_FIN);
        win_start_s = (state_s == S_ISSUE);
        res_we_s    = (state_s == S_WRITE);
        win_addr_s  = '0;
        res_addr_s  = '0;
        res_data_s  = 8'd0;
        if (busy_s) begin
            win_addr_s = pix_s;
        end else begin
            win_addr_s = '0;
        end
        if (res_we_s) begin
            res_addr_s = pix_s;
            res_data_s = div9(sum_s);
        end else begin
            res_addr_s = '0;
            res_data_s = 8'd0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_r       <= '0;
            wcnt_r      <= '0;
            sum_r       <= 12'd0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            win_start_r <= 1'b0;
            res_we_r    <= 1'b0;
            win_addr_r  <= '0;
            res_addr_r  <= '0;
            res_data_r  <= 8'd0;
        end else begin
            pix_r       <= pix_s;
            wcnt_r      <= wcnt_s;
            sum_r       <= sum_s;
            err_r       <= err_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            win_start_r <= win_start_s;
            res_we_r    <= res_we_s;
            win_addr_r  <= win_addr_s;
            res_addr_r  <= res_addr_s;
            res_data_r  <= res_data_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign win_start = win_start_r;
    assign win_addr  = win_addr_r;
    assign res_we    = res_we_r;
    assign res_addr  = res_addr_r;
    assign res_data  = res_data_r;

endmodule

// File: tb/tb_mean3x3_scan_ctrl.sv
// Scoreboard bench for mean3x3_scan_ctrl on a 16x16 image with a behavioural window block.
module tb_mean3x3_scan_ctrl;
    localparam int RB   = 4;
    localparam int CB   = 4;
    localparam int AW   = RB + CB;
    localparam int NCOL = 1 << CB;
    localparam int NROW = 1 << RB;
    localparam int NPIX = NROW * NCOL;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          win_finish = 1'b0;
    logic          res_ready = 1'b1;
    logic [7:0]    wv [9];
    logic          busy, done, err, win_start, res_we;
    logic [AW-1:0] win_addr, res_addr;
    logic [7:0]    res_data;

    logic [7:0] img [NPIX];
    int   sweep_sum [7] = '{0, 8, 9, 17, 18, 2294, 2295};
    int   sweep_exp [7] = '{0, 0, 1, 1, 2, 254, 255};
    exp_t sb_q [$];
    int   mode = 0;
    int   model_on = 1;
    int   exp_pix = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   n3_cnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    mean3x3_scan_ctrl #(.ROW_BITS(RB), .COL_BITS(CB), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .win_start(win_start), .win_addr(win_addr), .win_finish(win_finish),
        .win_v_1_1(wv[0]), .win_v_1_2(wv[1]), .win_v_1_3(wv[2]),
        .win_v_2_1(wv[3]), .win_v_2_2(wv[4]), .win_v_2_3(wv[5]),
        .win_v_3_1(wv[6]), .win_v_3_2(wv[7]), .win_v_3_3(wv[8]),
        .res_addr(res_addr), .res_data(res_data), .res_we(res_we), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int r, input int c);
        if (r < 0 || r >= NROW || c < 0 || c >= NCOL) return 8'd0;
        case (mode)
            0:       return 8'd0;
            1:       return 8'd255;
            default: return img[r*NCOL + c];
        endcase
    endfunction

    task automatic fill_win(input int p, output int s);
        int rem;
        s = 0;
        if (mode == 2 && p < 7) begin
            rem = sweep_sum[p];
            for (int i = 0; i < 9; i++) begin
                wv[i] = (rem > 255) ? 8'd255 : rem[7:0];
                rem -= int'(wv[i]);
            end
            s = sweep_sum[p];
        end else begin
            for (int i = 0; i < 9; i++) begin
                wv[i] = pix_val(p / NCOL + i / 3 - 1, p % NCOL + i % 3 - 1);
                s += int'(wv[i]);
            end
        end
    endtask

    // Window block model: answers each request 11 cycles later and queues the expected write
    initial begin
        int   p, s;
        exp_t e;
        for (int i = 0; i < 9; i++) wv[i] = 8'd0;
        forever begin
            @(negedge clk);
            if (win_start === 1'b1 && model_on != 0) begin
                chk("req_addr", 32'(win_addr), exp_pix);
                p = exp_pix;
                exp_pix++;
                repeat (11) @(posedge clk);
                #1;
                chk("addr_hold", 32'(win_addr), p);
                fill_win(p, s);
                e.addr = p;
                e.data = s / 9;
                sb_q.push_back(e);
                win_finish = 1'b1;
                @(posedge clk);
                #1;
                win_finish = 1'b0;
            end
        end
    end

    // Result monitor: pops the scoreboard on every accepted write
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (res_we === 1'b1 && res_ready === 1'b1) begin
                wr_cnt++;
                if (res_addr == AW'(3)) n3_cnt++;
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 32'(sb_q.size()), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_addr", 32'(res_addr), e.addr);
                    chk("res_data", 32'(res_data), e.data);
                    if (mode == 1 && e.addr == 0)  chk("t2_corner", 32'(res_data), 113);
                    if (mode == 1 && e.addr == 5)  chk("t2_edge", 32'(res_data), 170);
                    if (mode == 1 && e.addr == 18) chk("t2_inner", 32'(res_data), 255);
                    if (mode == 2 && e.addr < 7)   chk("t3_div", 32'(res_data), sweep_exp[e.addr]);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < budget) begin
            @(posedge clk); #1; cyc++;
        end
        chk("done_seen", 32'(done), 1);
    endtask

    task automatic scan_end(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 0);
        chk({tag, "_busy_off"}, 32'(busy), 0);
        chk({tag, "_writes"}, wr_cnt, NPIX);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_sb_left"}, 32'(sb_q.size()), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic new_scan(input int m);
        mode = m; exp_pix = 0; wr_cnt = 0; done_cnt = 0; n3_cnt = 0;
        do_start();
        chk("busy_on", 32'(busy), 1);
        chk("err_clr", 32'(err), 0);
    endtask

    initial begin
        int cyc, n;
        logic [AW-1:0] cap_a;
        logic [7:0]    cap_d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_wstart", 32'(win_start), 0);
        chk("rst_waddr", 32'(win_addr), 0);
        chk("rst_we", 32'(res_we), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 0);

        // T1: all-zero image, exact scan length
        new_scan(0);
        wait_done(20000, cyc);
        chk("t1_cycles", cyc, 13 * NPIX + 1);
        scan_end("t1");

        // T5: silent window block -> timeout abort
        model_on = 0; done_cnt = 0;
        do_start();
        cyc = 1;
        while (busy === 1'b1 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        chk("t5_cycles", cyc, 17);
        chk("t5_err", 32'(err), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_done", done_cnt, 0);
        chk("t5_sb", 32'(sb_q.size()), 0);
        model_on = 1;

        // T2: all-255 image, rescan from pixel 0 clears err
        new_scan(1);
        wait_done(20000, cyc);
        scan_end("t2");

        // T3 + T4: divider sweep on first pixels, random image, write stall on pixel 3
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
        new_scan(2);
        n = 0;
        while (!(win_start === 1'b1 && win_addr == AW'(3)) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("t4_req", 32'(win_addr), 3);
        @(posedge clk); #1; res_ready = 1'b0;
        n = 0;
        while (res_we !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        cap_a = res_addr;
        cap_d = res_data;
        chk("t4_addr", 32'(cap_a), 3);
        for (int i = 0; i < 5; i++) begin
            chk("t4_we", 32'(res_we), 1);
            chk("t4_addr_hold", 32'(res_addr), 32'(cap_a));
            chk("t4_data_hold", 32'(res_data), 32'(cap_d));
            chk("t4_no_req", 32'(win_start), 0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1; res_ready = 1'b1;
        @(negedge clk);
        chk("t4_xfer_no_req", 32'(win_start), 0);
        @(negedge clk);
        chk("t4_next_req", 32'(win_start), 1);
        chk("t4_next_addr", 32'(win_addr), 4);
        wait_done(20000, cyc);
        scan_end("t3");
        chk("t4_one_xfer", n3_cnt, 1);

        // T6: ignored start while busy, then async reset during pixel 50 write
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
        new_scan(2);
        n = 0;
        while (!(win_start === 1'b1 && win_addr == AW'(20)) && n < 400) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (!(res_we === 1'b1 && res_addr == AW'(50)) && n < 1000) begin
            @(negedge clk); n++;
        end
        chk("t6_at50", 32'(res_addr), 50);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_err", 32'(err), 0);
        chk("t6_wstart", 32'(win_start), 0);
        chk("t6_waddr", 32'(win_addr), 0);
        chk("t6_we", 32'(res_we), 0);
        chk("t6_raddr", 32'(res_addr), 0);
        chk("t6_rdata", 32'(res_data), 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_idle", 32'(busy), 0);
        chk("t6_no_done", done_cnt, 0);
        exp_pix = 0;
        do_start();
        chk("t6_restart_req", 32'(win_start), 1);
        chk("t6_restart_addr", 32'(win_addr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
